// File: rtl/intt_if.sv
// intt_if: request/result bundle for the Kyber inverse NTT.
// Master drives start/f_hat; slave returns f, busy, done.
interface intt_if;
  logic               start;
  logic [255:0][15:0] f_hat;
  logic [255:0][15:0] f;
  logic               busy;
  logic               done;

  modport master (
    output start,
    output f_hat,
    input  f,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  f_hat,
    output f,
    output busy,
    output done
  );
endinterface

// File: rtl/intt.sv
// intt: Kyber inverse NTT (Gentleman-Sande), q=3329, n=256.
// One butterfly per cycle, then one x3303 scaling multiply per cycle.
module intt (
  input  logic  clk,
  input  logic  reset_n,
  intt_if.slave bus
);

  localparam int          N     = 256;
  localparam logic [12:0] Q     = 13'd3329;
  localparam logic [11:0] F_INV = 12'd3303;
  localparam logic [24:0] BAR_M = 25'd20642678;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_BFLY  = 3'd2;
  localparam logic [2:0] S_SCALE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // 17^bitrev7(i) mod q, same table as the forward ntt block
  localparam logic [11:0] ZETAS [128] = '{
    12'd1,    12'd1729, 12'd2580, 12'd3289,
    12'd2642, 12'd630,  12'd1897, 12'd848,
    12'd1062, 12'd1919, 12'd193,  12'd797,
    12'd2786, 12'd3260, 12'd569,  12'd1746,
    12'd296,  12'd2447, 12'd1339, 12'd1476,
    12'd3046, 12'd56,   12'd2240, 12'd1333,
    12'd1426, 12'd2094, 12'd535,  12'd2882,
    12'd2393, 12'd2879, 12'd1974, 12'd821,
    12'd289,  12'd331,  12'd3253, 12'd1756,
    12'd1197, 12'd2304, 12'd2277, 12'd2055,
    12'd650,  12'd1977, 12'd2513, 12'd632,
    12'd2865, 12'd33,   12'd1320, 12'd1915,
    12'd2319, 12'd1435, 12'd807,  12'd452,
    12'd1438, 12'd2868, 12'd1534, 12'd2402,
    12'd2647, 12'd2617, 12'd1481, 12'd648,
    12'd2474, 12'd3110, 12'd1227, 12'd910,
    12'd17,   12'd2761, 12'd583,  12'd2649,
    12'd1637, 12'd723,  12'd2288, 12'd1100,
    12'd1409, 12'd2662, 12'd3281, 12'd233,
    12'd756,  12'd2156, 12'd3015, 12'd3050,
    12'd1703, 12'd1651, 12'd2789, 12'd1789,
    12'd1847, 12'd952,  12'd1461, 12'd2687,
    12'd939,  12'd2308, 12'd2437, 12'd2388,
    12'd733,  12'd2337, 12'd268,  12'd641,
    12'd1584, 12'd2298, 12'd2037, 12'd3220,
    12'd375,  12'd2549, 12'd2090, 12'd1645,
    12'd1063, 12'd319,  12'd2773, 12'd757,
    12'd2099, 12'd561,  12'd2466, 12'd2594,
    12'd2804, 12'd1092, 12'd403,  12'd1026,
    12'd1143, 12'd2150, 12'd2775, 12'd886,
    12'd1722, 12'd1212, 12'd1874, 12'd1029,
    12'd2110, 12'd2935, 12'd885,  12'd2154
  };

  // Barrett: quotient estimate is short by at most one,
  // so a single conditional subtract gives the exact residue.
  function automatic logic [11:0] red24(input logic [23:0] x);
    logic [48:0] p;
    logic [12:0] qe;
    logic [12:0] r;
    p  = {25'd0, x} * {24'd0, BAR_M};
    qe = 13'(p >> 36);
    r  = x[12:0] - qe * Q;
    if (r >= Q) r = r - Q;
    return r[11:0];
  endfunction

  // Same idea for the biased 17-bit load value (< 20q).
  function automatic logic [11:0] red17(input logic [16:0] u);
    logic [25:0] p;
    logic [4:0]  qe;
    logic [12:0] r;
    p  = {9'd0, u} * 26'd314;
    qe = 5'(p >> 20);
    r  = u[12:0] - {8'd0, qe} * Q;
    if (r >= Q) r = r - Q;
    return r[11:0];
  endfunction

  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic [11:0] fr [N];
  logic [2:0]  layer;
  logic [6:0]  b;
  logic [6:0]  k;
  logic [7:0]  s;
  logic        busy_q;
  logic        done_q;

  logic [7:0]  len;
  logic [7:0]  mask;
  logic [7:0]  off;
  logic [7:0]  jj;
  logic [7:0]  jh;
  logic [11:0] a;
  logic [11:0] c;
  logic [11:0] zeta;
  logic [12:0] sum;
  logic [11:0] sum_r;
  logic [11:0] diff;
  logic [11:0] bf_t;
  logic [11:0] sc_r;
  logic        grp_end;
  logic        lay_end;
  logic        last;

  // Butterfly addressing and arithmetic, plus the scaling multiply
  always_comb begin
    len  = 8'd2 << layer;
    mask = len - 8'd1;
    off  = {1'b0, b} & mask;
    jj   = (({1'b0, b} >> ({1'b0, layer} + 4'd1))
           << ({1'b0, layer} + 4'd2)) | off;
    jh   = jj | len;
    a    = fr[jj];
    c    = fr[jh];
    zeta = ZETAS[k];
    sum  = {1'b0, a} + {1'b0, c};
    sum_r = (sum >= Q) ? 12'(sum - Q) : sum[11:0];
    diff = (c >= a) ? (c - a)
                    : 12'({1'b0, c} + Q - {1'b0, a});
    bf_t = red24(24'(zeta) * 24'(diff));
    grp_end = (off == mask);
    lay_end = (b == 7'd127);
    last    = lay_end && (layer == 3'd6);
    sc_r = red24(24'(fr[s]) * 24'(F_INV));
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (bus.start) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_BFLY;
      S_BFLY:  if (last) state_nx = S_SCALE;
      S_SCALE: if (s == 8'd255) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Layer / butterfly / zeta / scale counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      layer <= 3'd0;
      b     <= 7'd0;
      k     <= 7'd0;
      s     <= 8'd0;
    end else begin
      unique case (state)
        S_LOAD: begin
          layer <= 3'd0;
          b     <= 7'd0;
          k     <= 7'd127;
          s     <= 8'd0;
        end
        S_BFLY: begin
          b <= b + 7'd1;
          if (lay_end && !last) layer <= layer + 3'd1;
          if (grp_end && k != 7'd0) k <= k - 7'd1;
        end
        S_SCALE: begin
          assert (k == 7'd0);
          s <= s + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Coefficient store: load, butterfly pair write, scale write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) fr[i] <= 12'd0;
    end else begin
      unique case (state)
        S_LOAD: begin
          for (int i = 0; i < N; i++)
            fr[i] <= red17({bus.f_hat[i][15], bus.f_hat[i]}
                           + 17'd33290);
        end
        S_BFLY: begin
          fr[jj] <= sum_r;
          fr[jh] <= bf_t;
        end
        S_SCALE: fr[s] <= sc_r;
        default: ;
      endcase
    end
  end

  // Registered status: busy covers LOAD..SCALE, done follows DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state == S_LOAD) || (state == S_BFLY)
             || (state == S_SCALE);
      done_q <= (state == S_DONE);
    end
  end

  // Drive result and status onto the bundle
  always_comb begin
    for (int i = 0; i < N; i++) bus.f[i] = {4'd0, fr[i]};
    bus.busy = busy_q;
    bus.done = done_q;
  end

endmodule

// File: tb/tb_intt.sv
// tb_intt: scoreboard bench for the intt block.
// Driver queues expected polynomials; monitor checks on done.
module tb_intt;

  localparam int Q = 3329;

  typedef logic [255:0][15:0] poly_t;
  typedef struct {
    poly_t exp;
    int    e;
    int    id;
  } item_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  intt_if bus();

  intt dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  item_t sb[$];
  item_t it;
  int cyc = 0;
  int n_test = 0;
  int n_fail = 0;
  int busy_cnt = 0;
  int zt[128];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int mq(input int x);
    int r;
    r = x % Q;
    if (r < 0) r += Q;
    return r;
  endfunction

  function automatic int brv7(input int i);
    int r;
    r = 0;
    for (int j = 0; j < 7; j++) r |= ((i >> j) & 1) << (6 - j);
    return r;
  endfunction

  // Forward NTT reference used to build round-trip inputs
  function automatic poly_t ntt_fwd(input int fin[256]);
    int f[256];
    int k;
    int z;
    int t;
    poly_t o;
    for (int i = 0; i < 256; i++) f[i] = fin[i];
    k = 1;
    for (int len = 128; len >= 2; len = len / 2) begin
      for (int st = 0; st < 256; st += 2 * len) begin
        z = zt[k];
        k++;
        for (int j = st; j < st + len; j++) begin
          t = (z * f[j + len]) % Q;
          f[j + len] = mq(f[j] - t);
          f[j] = (f[j] + t) % Q;
        end
      end
    end
    for (int i = 0; i < 256; i++) o[i] = 16'(f[i]);
    return o;
  endfunction

  task automatic check(input string nm, input int got,
                       input int want);
    n_test++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic check_poly(input string nm, input poly_t got,
                            input poly_t want);
    int bad;
    bad = -1;
    n_test++;
    for (int i = 255; i >= 0; i--)
      if (got[i] != want[i]) bad = i;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s idx %0d got %0d want %0d",
               nm, bad, got[bad], want[bad]);
    end
  endtask

  // Monitor: pop and compare whenever the DUT signals done
  always @(negedge clk) begin
    if (!reset_n) busy_cnt = 0;
    else if (bus.busy) busy_cnt++;
    if (bus.done) begin
      if (sb.size() == 0) begin
        n_test++;
        n_fail++;
        $display("FAIL unexpected_done cycle %0d got 1 want 0", cyc);
      end else begin
        it = sb.pop_front();
        check_poly($sformatf("poly_t%0d", it.id), bus.f, it.exp);
        check($sformatf("latency_t%0d", it.id), cyc - it.e, 1154);
        check($sformatf("busy_cyc_t%0d", it.id), busy_cnt, 1153);
        check($sformatf("busy_done_t%0d", it.id), int'(bus.busy), 0);
      end
      busy_cnt = 0;
    end
  end

  task automatic issue(input poly_t fh, input poly_t ex,
                       input int id, input bit push, input bit hold);
    bus.f_hat = fh;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (push) sb.push_back('{exp: ex, e: cyc, id: id});
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 5000) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (sb.size() != 0) begin
      n_test++;
      n_fail++;
      $display("FAIL %s timeout pending %0d want 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_done(input string nm);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    while (n < 2000) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    if (!ok) begin
      n_test++;
      n_fail++;
      $display("FAIL %s timeout done got 0 want 1", nm);
      sb.delete();
    end
  endtask

  initial begin
    poly_t zero;
    poly_t p_one;
    poly_t e_one;
    poly_t p_x;
    poly_t e_x;
    poly_t p_oor;
    poly_t fh;
    poly_t ex;
    int fv[256];
    int v;
    int e0;

    bus.start = 1'b0;
    bus.f_hat = '0;
    zero  = '0;
    p_one = '0;
    e_one = '0;
    p_x   = '0;
    e_x   = '0;
    p_oor = '0;
    e_one[0] = 16'd1;
    e_x[1]   = 16'd1;
    for (int i = 0; i < 256; i++) begin
      if (i % 2 == 0) begin
        p_one[i] = 16'd1;
        p_oor[i] = ((i / 2) % 2 == 0) ? 16'(-3328) : 16'(3330);
      end else begin
        p_x[i]   = 16'd1;
        p_oor[i] = 16'(3329);
      end
    end
    for (int i = 0; i < 128; i++) begin
      v = 1;
      for (int j = 0; j < brv7(i); j++) v = (v * 17) % Q;
      zt[i] = v;
    end

    #23 reset_n = 1'b1;
    @(negedge clk);
    check_poly("reset_f", bus.f, zero);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);

    @(negedge clk); issue(zero, zero, 1, 1, 0); drain("t1");
    @(negedge clk); issue(p_one, e_one, 2, 1, 0); drain("t2");
    @(negedge clk); issue(p_x, e_x, 3, 1, 0); drain("t3");
    @(negedge clk); issue(p_oor, e_one, 4, 1, 0); drain("t4");

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 256; i++) begin
        fv[i] = $urandom_range(3328);
        ex[i] = 16'(fv[i]);
      end
      fh = ntt_fwd(fv);
      if (t == 2) begin
        for (int i = 0; i < 256; i++) begin
          v = int'(fh[i]);
          if (i % 3 == 0) v += 5 * Q;
          else if (i % 3 == 1) v -= 9 * Q;
          fh[i] = 16'(v);
        end
      end
      @(negedge clk);
      issue(fh, ex, 5 + t, 1, 0);
      drain("rt");
    end

    @(negedge clk);
    issue(p_oor, e_one, 8, 1, 0);
    wait_done("b2b_a");
    issue(p_x, e_x, 9, 1, 0);
    drain("b2b");

    @(negedge clk);
    issue(p_x, e_x, 10, 1, 1);
    wait_done("hold");
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    check("hold_busy", int'(bus.busy), 0);
    check("hold_queue", sb.size(), 0);

    @(negedge clk);
    issue(p_one, e_one, 11, 0, 0);
    e0 = cyc;
    while (cyc < e0 + 500) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_poly("abort_f", bus.f, zero);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (1200) @(negedge clk);
    check("abort_idle", int'(bus.busy), 0);

    @(negedge clk); issue(p_one, e_one, 12, 1, 0); drain("fresh");

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule
